// File: rtl/proc_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle core: generates the commit
// enable, stalls IN instructions for switch confirmation, and flags program end.
module proc_run_ctrl #(
  parameter int PC_W  = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             halt_i,
  input  logic             sw_ok_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  output logic             exec_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_WAIT_SW = 2'd2,
    S_BREAK   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_run_q;
  logic             r_step_q;
  logic             r_sw_q;
  logic             r_done;
  logic             r_skip;
  logic             r_step_mode;
  logic [CNT_W-1:0] r_cnt;

  logic w_run_rise;
  logic w_step_rise;
  logic w_sw_rise;
  logic w_is_in;
  logic w_is_self;
  logic w_bp_hit;
  logic w_exec;
  logic w_set_done;
  logic w_set_skip;
  logic w_step_mode_nxt;

  assign w_run_rise  = run_i & ~r_run_q;
  assign w_step_rise = step_i & ~r_step_q;
  assign w_sw_rise   = sw_ok_i & ~r_sw_q;
  assign w_is_in     = (instr_i[29:28] == 2'b01);
  assign w_is_self   = instr_i[31] & (instr_i[7:0] == 8'h00);
  assign w_bp_hit    = bp_en_i & (pc_i == bp_addr_i) & ~r_skip;

  always_comb begin
    w_next          = r_state;
    w_exec          = 1'b0;
    w_set_done      = 1'b0;
    w_set_skip      = 1'b0;
    w_step_mode_nxt = r_step_mode;
    case (r_state)
      S_IDLE: begin
        if (!r_done) begin
          if (w_run_rise) begin
            w_next = S_RUN;
          end else if (w_step_rise) begin
            if (w_is_self) begin
              w_set_done = 1'b1;
            end else if (w_is_in) begin
              w_next          = S_WAIT_SW;
              w_step_mode_nxt = 1'b1;
            end else begin
              w_exec = 1'b1;
            end
          end
        end
      end
      S_RUN: begin
        if (w_is_self) begin
          w_next     = S_IDLE;
          w_set_done = 1'b1;
        end else if (w_bp_hit) begin
          w_next = S_BREAK;
        end else if (w_is_in) begin
          w_next          = S_WAIT_SW;
          w_step_mode_nxt = 1'b0;
        end else begin
          w_exec = 1'b1;
        end
      end
      S_WAIT_SW: begin
        if (w_sw_rise) begin
          w_exec = 1'b1;
          w_next = r_step_mode ? S_IDLE : S_RUN;
        end
      end
      default: begin
        // Resuming from a breakpoint arms skip so the same PC is not re-trapped.
        if (w_run_rise) begin
          w_next     = S_RUN;
          w_set_skip = 1'b1;
        end else if (w_step_rise) begin
          w_next     = S_IDLE;
          w_set_skip = 1'b1;
        end
      end
    endcase
    if (halt_i) begin
      w_next          = S_IDLE;
      w_exec          = 1'b0;
      w_set_done      = 1'b0;
      w_set_skip      = 1'b0;
      w_step_mode_nxt = r_step_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_run_q     <= 1'b0;
      r_step_q    <= 1'b0;
      r_sw_q      <= 1'b0;
      r_done      <= 1'b0;
      r_skip      <= 1'b0;
      r_step_mode <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next;
      r_run_q     <= run_i;
      r_step_q    <= step_i;
      r_sw_q      <= sw_ok_i;
      r_done      <= r_done | w_set_done;
      r_step_mode <= w_step_mode_nxt;
      if (w_exec) begin
        r_skip <= 1'b0;
        r_cnt  <= r_cnt + CNT_W'(1);
      end else if (w_set_skip) begin
        r_skip <= 1'b1;
      end
    end
  end

  assign exec_o      = w_exec & ~reset;
  assign state_o     = r_state;
  assign done_o      = r_done;
  assign instr_cnt_o = r_cnt;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl; a tiny core model advances the PC on commit.
module tb_proc_run_ctrl;

  localparam logic [31:0] ADD  = 32'h0000_0123;
  localparam logic [31:0] INI  = 32'h1000_0040;
  localparam logic [31:0] JSLF = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_i = 1'b0;
  logic        step_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        sw_ok_i = 1'b0;
  logic        bp_en_i = 1'b0;
  logic [6:0]  bp_addr_i = '0;
  logic [6:0]  pc_i = '0;
  logic [31:0] instr_i;
  logic        exec_o;
  logic [1:0]  state_o;
  logic        done_o;
  logic [15:0] instr_cnt_o;

  logic [31:0] prog [0:127];
  int n_checks = 0;
  int n_fail   = 0;

  assign instr_i = prog[pc_i];

  always #5 clk = ~clk;

  proc_run_ctrl #(.PC_W(7), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
    .sw_ok_i(sw_ok_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i),
    .instr_i(instr_i), .exec_o(exec_o), .state_o(state_o), .done_o(done_o),
    .instr_cnt_o(instr_cnt_o)
  );

  // One clock: the PC advances when a commit was enabled before the edge.
  task automatic cyc();
    logic e;
    #1;
    e = exec_o;
    @(posedge clk);
    #1;
    if (e) pc_i = pc_i + 7'd1;
    #1;
  endtask

  task automatic fill_add();
    for (int i = 0; i < 128; i++) prog[i] = ADD;
  endtask

  task automatic do_reset();
    reset = 1'b1; run_i = 1'b0; step_i = 1'b0; halt_i = 1'b0;
    sw_ok_i = 1'b0; bp_en_i = 1'b0; pc_i = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    fill_add();
    reset = 1'b1; run_i = 1'b1;
    cyc(); cyc();
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL reset_exec got %0b want 0", exec_o); end
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_o); end
    n_checks++;
    if (done_o !== 1'b0 || instr_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_done_cnt got %0b/%0d want 0/0", done_o, instr_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_run_to_end();
    int n;
    do_reset();
    fill_add();
    prog[3] = JSLF;
    run_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL run_rise_exec got %0b want 0", exec_o); end
    cyc();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (state_o == 2'd0) break;
      if (exec_o) n++;
      cyc();
    end
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL run_exec_cycles got %0d want 3", n); end
    n_checks++;
    if (instr_cnt_o !== 16'd3) begin n_fail++; $display("FAIL run_cnt got %0d want 3", instr_cnt_o); end
    n_checks++;
    if (state_o !== 2'd0 || done_o !== 1'b1) begin
      n_fail++; $display("FAIL run_end got state %0d done %0b want 0/1", state_o, done_o);
    end
    run_i = 1'b0; cyc();
    run_i = 1'b1; step_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL done_ignore_exec got %0b want 0", exec_o); end
    cyc(); cyc();
    n_checks++;
    if (state_o !== 2'd0 || instr_cnt_o !== 16'd3) begin
      n_fail++; $display("FAIL done_ignore got state %0d cnt %0d want 0/3", state_o, instr_cnt_o);
    end
    run_i = 1'b0; step_i = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    fill_add();
    for (int k = 0; k < 3; k++) begin
      step_i = 1'b1; #1;
      n_checks++;
      if (exec_o !== 1'b1) begin n_fail++; $display("FAIL step_pulse_%0d got %0b want 1", k, exec_o); end
      cyc();
      n_checks++;
      if (exec_o !== 1'b0 || state_o !== 2'd0) begin
        n_fail++; $display("FAIL step_after_%0d got exec %0b state %0d want 0/0", k, exec_o, state_o);
      end
      step_i = 1'b0;
      cyc();
    end
    n_checks++;
    if (instr_cnt_o !== 16'd3 || pc_i !== 7'd3) begin
      n_fail++; $display("FAIL step_cnt got cnt %0d pc %0d want 3/3", instr_cnt_o, pc_i);
    end
    run_i = 1'b1; step_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL run_step_tie_exec got %0b want 0", exec_o); end
    cyc();
    n_checks++;
    if (state_o !== 2'd1) begin n_fail++; $display("FAIL run_beats_step got %0d want 1", state_o); end
    run_i = 1'b0; step_i = 1'b0;
  endtask

  task automatic test_breakpoint();
    do_reset();
    fill_add();
    bp_en_i = 1'b1; bp_addr_i = 7'd5;
    run_i = 1'b1; #1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      if (state_o == 2'd3) break;
      cyc();
    end
    n_checks++;
    if (state_o !== 2'd3 || pc_i !== 7'd5 || exec_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_hit got state %0d pc %0d exec %0b want 3/5/0", state_o, pc_i, exec_o);
    end
    n_checks++;
    if (instr_cnt_o !== 16'd5) begin n_fail++; $display("FAIL bp_cnt got %0d want 5", instr_cnt_o); end
    run_i = 1'b0; cyc();
    run_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL bp_resume_exec got %0b want 0", exec_o); end
    cyc();
    n_checks++;
    if (state_o !== 2'd1 || exec_o !== 1'b1 || pc_i !== 7'd5) begin
      n_fail++; $display("FAIL bp_skip got state %0d exec %0b pc %0d want 1/1/5", state_o, exec_o, pc_i);
    end
    cyc();
    for (int i = 0; i < 300; i++) begin
      if (state_o == 2'd3) break;
      cyc();
    end
    n_checks++;
    if (state_o !== 2'd3 || pc_i !== 7'd5) begin
      n_fail++; $display("FAIL bp_rehit got state %0d pc %0d want 3/5", state_o, pc_i);
    end
    reset = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL bp_reset_exec got %0b want 0", exec_o); end
    cyc();
    n_checks++;
    if (state_o !== 2'd0 || instr_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL bp_reset got state %0d cnt %0d want 0/0", state_o, instr_cnt_o);
    end
    reset = 1'b0; run_i = 1'b0; bp_en_i = 1'b0;
    #1;
  endtask

  task automatic test_wait_sw();
    int bad;
    logic [15:0] c;
    do_reset();
    fill_add();
    prog[2] = INI;
    run_i = 1'b1; #1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      if (state_o == 2'd2) break;
      cyc();
    end
    n_checks++;
    if (state_o !== 2'd2 || pc_i !== 7'd2 || instr_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL in_stall got state %0d pc %0d cnt %0d want 2/2/2", state_o, pc_i, instr_cnt_o);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (exec_o !== 1'b0 || state_o !== 2'd2) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL in_hold got %0d bad cycles want 0", bad); end
    sw_ok_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b1) begin n_fail++; $display("FAIL sw_commit got %0b want 1", exec_o); end
    cyc();
    n_checks++;
    if (state_o !== 2'd1 || pc_i !== 7'd3) begin
      n_fail++; $display("FAIL sw_resume got state %0d pc %0d want 1/3", state_o, pc_i);
    end
    halt_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL halt_run_exec got %0b want 0", exec_o); end
    cyc();
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL halt_run_state got %0d want 0", state_o); end
    halt_i = 1'b0; run_i = 1'b0; sw_ok_i = 1'b0;
    prog[pc_i] = INI;
    cyc();
    step_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0) begin n_fail++; $display("FAIL step_in_exec got %0b want 0", exec_o); end
    cyc();
    n_checks++;
    if (state_o !== 2'd2) begin n_fail++; $display("FAIL step_in_state got %0d want 2", state_o); end
    step_i = 1'b0;
    sw_ok_i = 1'b1; #1;
    c = instr_cnt_o;
    n_checks++;
    if (exec_o !== 1'b1) begin n_fail++; $display("FAIL step_sw_commit got %0b want 1", exec_o); end
    cyc();
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL step_sw_state got %0d want 0", state_o); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (exec_o !== 1'b0) bad++;
      cyc();
    end
    n_checks++;
    if (bad != 0 || instr_cnt_o !== 16'(c + 16'd1)) begin
      n_fail++; $display("FAIL sw_held got %0d extra, cnt %0d want 0, %0d", bad, instr_cnt_o, 16'(c + 16'd1));
    end
    sw_ok_i = 1'b0;
    prog[pc_i] = INI;
    cyc();
    step_i = 1'b1; #1;
    cyc();
    step_i = 1'b0;
    halt_i = 1'b1; #1;
    n_checks++;
    if (exec_o !== 1'b0 || state_o !== 2'd2) begin
      n_fail++; $display("FAIL halt_wait got exec %0b state %0d want 0/2", exec_o, state_o);
    end
    cyc();
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL halt_wait_state got %0d want 0", state_o); end
    halt_i = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    fill_add();
    run_i = 1'b1; #1;
    cyc();
    for (int i = 0; i < 70000; i++) begin
      if (instr_cnt_o == 16'hFFFF) break;
      cyc();
    end
    n_checks++;
    if (instr_cnt_o !== 16'hFFFF || exec_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap_preload got cnt %0h exec %0b want ffff/1", instr_cnt_o, exec_o);
    end
    cyc();
    n_checks++;
    if (instr_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL wrap got %0h want 0", instr_cnt_o); end
    run_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_to_end();
    test_step();
    test_breakpoint();
    test_wait_sw();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
